// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: computes result/Zero from ALUControl and presents them
// through a valid/ready output register backed by a one-entry skid buffer.
// Optional operand forwarding from the last producer is enabled by `ALU_EXEC_FWD_EN.
//
// Handshake: a beat moves across an interface on a rising edge where valid && ready.
// The upstream side must hold its beat until accepted; the stage holds out_valid and
// all output data stable while out_valid && !out_ready.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            RegWrite,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            IllegalOp,
  output logic [4:0]      out_rd,
  output logic            out_RegWrite
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [4:0]      rd;
    logic            regwrite;
  } entry_t;

  entry_t          or_q;
  entry_t          sk_q;
  logic            or_valid;
  logic            sk_valid;

  entry_t          beat;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            illegal;
  logic            slt;
  logic            accept;

  // Ready depends only on registered skid state, so it never combinationally follows out_ready.
  assign in_ready = ~sk_valid & ~reset;
  assign accept   = in_valid & in_ready;

`ifdef ALU_EXEC_FWD_EN
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_result;
  logic            fwd_we;

  always_comb begin
    op_a = SrcA;
    op_b = SrcB;
    if (fwd_we && (rs1 != 5'd0) && (rs1 == fwd_rd)) op_a = fwd_result;
    if (fwd_we && (rs2 != 5'd0) && (rs2 == fwd_rd)) op_b = fwd_result;
  end

  // Last-producer record; any accepted beat that does not write a register invalidates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_rd     <= 5'd0;
      fwd_result <= '0;
      fwd_we     <= 1'b0;
    end else if (accept) begin
      if (RegWrite && !illegal) begin
        fwd_rd     <= rd;
        fwd_result <= alu_res;
        fwd_we     <= 1'b1;
      end else begin
        fwd_we     <= 1'b0;
      end
    end
  end
`else
  logic unused_src_idx;

  assign op_a           = SrcA;
  assign op_b           = SrcB;
  assign unused_src_idx = ^{rs1, rs2};
`endif

  assign slt = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    case (ALUControl)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt};
      default: illegal = 1'b1;
    endcase
  end

  // Reserved codes leave alu_res at zero, so Zero reads 1 for them as well.
  always_comb begin
    beat          = '0;
    beat.result   = alu_res;
    beat.zero     = (alu_res == '0);
    beat.illegal  = illegal;
    beat.rd       = rd;
    beat.regwrite = RegWrite & ~illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      or_q     <= '0;
      sk_q     <= '0;
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (!or_valid || out_ready) begin
      // OR is free this cycle: the older skid entry always goes first to keep order.
      if (sk_valid) begin
        or_q     <= sk_q;
        or_valid <= 1'b1;
        sk_valid <= accept;
        if (accept) sk_q <= beat;
      end else begin
        or_valid <= accept;
        if (accept) or_q <= beat;
      end
    end else if (accept) begin
      sk_q     <= beat;
      sk_valid <= 1'b1;
    end
  end

  assign out_valid    = or_valid;
  assign ALUResult    = or_q.result;
  assign Zero         = or_q.zero;
  assign IllegalOp    = or_q.illegal;
  assign out_rd       = or_q.rd;
  assign out_RegWrite = or_q.regwrite;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized traffic
// scored against a queue-based occupancy/ordering model of the stage.
module tb_alu_exec_stage;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        ill;
    logic [4:0]  rd;
    logic        we;
  } beat_t;

`ifdef ALU_EXEC_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        RegWrite;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        IllegalOp;
  logic [4:0]  out_rd;
  logic        out_RegWrite;

  int          vectors = 0;
  int          miscompares = 0;
  beat_t       exp_q[$];
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_res = 32'd0;
  logic        m_we = 1'b0;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .rs1(rs1), .rs2(rs2),
    .rd(rd), .RegWrite(RegWrite), .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .IllegalOp(IllegalOp), .out_rd(out_rd),
    .out_RegWrite(out_RegWrite)
  );

  always #5 clk = ~clk;

  // Reference: what the stage must emit for a beat, from the operation table.
  function automatic beat_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] d, input logic w);
    beat_t e;
    logic [31:0] x;
    logic [31:0] y;
    x = a;
    y = b;
    if (FWD && m_we && r1 != 5'd0 && r1 == m_rd) x = m_res;
    if (FWD && m_we && r2 != 5'd0 && r2 == m_rd) y = m_res;
    e.ill = (c > 3'd4);
    case (c)
      3'd0:    e.res = x + y;
      3'd1:    e.res = x - y;
      3'd2:    e.res = x & y;
      3'd3:    e.res = x | y;
      3'd4:    e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: e.res = 32'd0;
    endcase
    e.z  = (e.res == 32'd0);
    e.rd = d;
    e.we = w && !e.ill;
    if (w && !e.ill) begin
      m_rd  = d;
      m_res = e.res;
      m_we  = 1'b1;
    end else begin
      m_we  = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: occupancy and order model, evaluated mid-cycle on the pre-edge state.
  task automatic scoreboard();
    beat_t got;
    bit    exp_rdy;
    forever begin
      @(negedge clk);
      if (reset) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL sb_in_ready_in_reset got=%0b exp=0", in_ready);
        end
        exp_q.delete();
        m_we = 1'b0;
        m_rd = 5'd0;
        m_res = 32'd0;
      end else begin
        exp_rdy = (exp_q.size() < 2);
        vectors++;
        if (in_ready !== exp_rdy) begin
          miscompares++;
          $display("FAIL sb_in_ready t=%0t got=%0b exp=%0b", $time, in_ready, exp_rdy);
        end
        vectors++;
        if (out_valid !== (exp_q.size() > 0)) begin
          miscompares++;
          $display("FAIL sb_out_valid t=%0t got=%0b exp=%0b", $time, out_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
          got = {ALUResult, Zero, IllegalOp, out_rd, out_RegWrite};
          vectors++;
          if (got !== exp_q[0]) begin
            miscompares++;
            $display("FAIL sb_beat t=%0t got=%h exp=%h", $time, got, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
        if (in_valid && exp_rdy)
          exp_q.push_back(model(ALUControl, SrcA, SrcB, rs1, rs2, rd, RegWrite));
      end
    end
  endtask

  task automatic set_beat(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] d, input logic w);
    ALUControl = c;
    SrcA = a;
    SrcB = b;
    rs1 = r1;
    rs2 = r2;
    rd = d;
    RegWrite = w;
    in_valid = 1'b1;
  endtask

  // One beat presented for one edge; caller guarantees the stage is ready.
  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input logic w);
    set_beat(c, a, b, r1, r2, d, w);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, ALUResult, Zero, IllegalOp, out_rd, out_RegWrite} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%0b/%h/%0b/%0b/%0d/%0b exp=all zero",
               out_valid, ALUResult, Zero, IllegalOp, out_rd, out_RegWrite);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_alu_ops();
    out_ready = 1'b1;
    drive(3'b000, 32'd7, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd12 || Zero !== 1'b0) begin
      miscompares++;
      $display("FAIL add_7_5 got v=%0b r=%0d z=%0b exp v=1 r=12 z=0", out_valid, ALUResult, Zero);
    end
    drive(3'b001, 32'd5, 32'd5, 5'd0, 5'd0, 5'd2, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_5_5 got v=%0b r=%0d z=%0b exp v=1 r=0 z=1", out_valid, ALUResult, Zero);
    end
    drive(3'b100, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0, 5'd3, 1'b1);
    vectors++;
    if (ALUResult !== 32'd1) begin
      miscompares++;
      $display("FAIL slt_neg1_1 got=%h exp=1", ALUResult);
    end
    drive(3'b100, 32'd1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd3, 1'b1);
    vectors++;
    if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
      miscompares++;
      $display("FAIL slt_1_neg1 got r=%h z=%0b exp r=0 z=1", ALUResult, Zero);
    end
    drive(3'b000, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0, 5'd4, 1'b1);
    vectors++;
    if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
      miscompares++;
      $display("FAIL add_wrap got r=%h z=%0b exp r=0 z=1", ALUResult, Zero);
    end
    drive(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 5'd0, 5'd0, 1'b1);
    vectors++;
    if (ALUResult !== 32'h00F0_1200 || out_rd !== 5'd0 || out_RegWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL and_x0 got r=%h rd=%0d we=%0b exp r=00f01200 rd=0 we=1", ALUResult, out_rd, out_RegWrite);
    end
    drive(3'b011, 32'hF000_0001, 32'h0000_0100, 5'd0, 5'd0, 5'd9, 1'b0);
    vectors++;
    if (ALUResult !== 32'hF000_0101 || out_RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL or_op got r=%h we=%0b exp r=f0000101 we=0", ALUResult, out_RegWrite);
    end
    drive(3'b110, 32'd9, 32'd9, 5'd0, 5'd0, 5'd7, 1'b1);
    vectors++;
    if (IllegalOp !== 1'b1 || ALUResult !== 32'd0 || out_RegWrite !== 1'b0 || Zero !== 1'b1 || out_rd !== 5'd7) begin
      miscompares++;
      $display("FAIL illegal_110 got ill=%0b r=%h we=%0b z=%0b rd=%0d exp 1/0/0/1/7",
               IllegalOp, ALUResult, out_RegWrite, Zero, out_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_beat(3'b000, 32'd10, 32'd1, 5'd0, 5'd0, 5'd1, 1'b1);
    @(posedge clk);
    #1;
    set_beat(3'b000, 32'd20, 32'd2, 5'd0, 5'd0, 5'd2, 1'b1);
    @(posedge clk);
    #1;
    set_beat(3'b000, 32'd30, 32'd3, 5'd0, 5'd0, 5'd3, 1'b1);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || ALUResult !== 32'd11) begin
      miscompares++;
      $display("FAIL bp_full got rdy=%0b v=%0b r=%0d exp 0/1/11", in_ready, out_valid, ALUResult);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0 || ALUResult !== 32'd11) begin
      miscompares++;
      $display("FAIL bp_hold got rdy=%0b r=%0d exp 0/11", in_ready, ALUResult);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (ALUResult !== 32'd22 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain2 got r=%0d rdy=%0b exp 22/1", ALUResult, in_ready);
    end
    @(posedge clk);
    #1;
    set_beat(3'b000, 32'd40, 32'd4, 5'd0, 5'd0, 5'd4, 1'b1);
    vectors++;
    if (ALUResult !== 32'd33) begin
      miscompares++;
      $display("FAIL bp_drain3 got r=%0d exp 33", ALUResult);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (ALUResult !== 32'd44 || out_rd !== 5'd4) begin
      miscompares++;
      $display("FAIL bp_drain4 got r=%0d rd=%0d exp 44/4", ALUResult, out_rd);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty got v=%0b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    set_beat(3'b000, 32'd1, 32'd1, 5'd0, 5'd0, 5'd1, 1'b1);
    @(posedge clk);
    #1;
    set_beat(3'b000, 32'd2, 32'd2, 5'd0, 5'd0, 5'd2, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got v=%0b rdy=%0b exp 0/0", out_valid, in_ready);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_empty got v=%0b exp 0", out_valid);
    end
    drive(3'b000, 32'd100, 32'd23, 5'd0, 5'd0, 5'd8, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd123) begin
      miscompares++;
      $display("FAIL first_after_reset got v=%0b r=%0d exp 1/123", out_valid, ALUResult);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_forwarding();
    out_ready = 1'b1;
    drive(3'b000, 32'd3, 32'd4, 5'd0, 5'd0, 5'd5, 1'b1);
    drive(3'b000, 32'd0, 32'd1, 5'd5, 5'd0, 5'd6, 1'b0);
    vectors++;
    if (ALUResult !== (FWD ? 32'd8 : 32'd1)) begin
      miscompares++;
      $display("FAIL fwd_rs1 got=%0d exp=%0d", ALUResult, FWD ? 8 : 1);
    end
    drive(3'b000, 32'd3, 32'd4, 5'd0, 5'd0, 5'd9, 1'b1);
    drive(3'b001, 32'd20, 32'd0, 5'd0, 5'd9, 5'd6, 1'b0);
    vectors++;
    if (ALUResult !== (FWD ? 32'd13 : 32'd20)) begin
      miscompares++;
      $display("FAIL fwd_rs2 got=%0d exp=%0d", ALUResult, FWD ? 13 : 20);
    end
    drive(3'b000, 32'd3, 32'd4, 5'd0, 5'd0, 5'd0, 1'b1);
    drive(3'b000, 32'd0, 32'd1, 5'd0, 5'd0, 5'd6, 1'b0);
    vectors++;
    if (ALUResult !== 32'd1) begin
      miscompares++;
      $display("FAIL fwd_x0 got=%0d exp=1", ALUResult);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_beat(3'($urandom_range(0, 7)), rand_op(), rand_op(), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      in_valid = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got pending=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ALUControl = 3'd0;
    SrcA = 32'd0;
    SrcB = 32'd0;
    rs1 = 5'd0;
    rs2 = 5'd0;
    rd = 5'd0;
    RegWrite = 1'b0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_reset_midstream();
    test_forwarding();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
